// File: rtl/nibbler_io_pkg.sv
// rtl/nibbler_io_pkg.sv - shared width and debounce state type for the Nibbler pushbutton input stage
package nibbler_io_pkg;
   localparam int NIB_W = 4;
   typedef enum logic {DB_STABLE, DB_PENDING} db_state_t;
endpackage

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - button lines, ack and conditioned outputs between board and CPU input stage
interface button_conditioner_if
   import nibbler_io_pkg::*;
#(
   parameter int WIDTH = NIB_W
);
   logic [WIDTH-1:0] btn_raw;
   logic             ack;
   logic [WIDTH-1:0] buttons;
   logic [WIDTH-1:0] press_pulse;

   modport master (output btn_raw, output ack, input buttons, input press_pulse);
   modport slave  (input btn_raw, input ack, output buttons, output press_pulse);
endinterface

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one button line: synchroniser chain, debounce FSM with counter, registered press pulse
module debounce_bit
   import nibbler_io_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_stable,
   output logic o_press
);
   localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   db_state_t              r_state, w_state_nxt;
   logic [CW-1:0]          r_cnt, w_cnt_nxt;
   logic                   r_stable, w_stable_nxt;
   logic                   r_press, w_press_nxt;
   logic                   w_sync;

   assign w_sync = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync   <= '0;
         r_state  <= DB_STABLE;
         r_cnt    <= '0;
         r_stable <= 1'b0;
         r_press  <= 1'b0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], i_raw};
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_stable <= w_stable_nxt;
         r_press  <= w_press_nxt;
      end
   end

   // Any sample matching the accepted level aborts the pending change.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_stable_nxt = r_stable;
      w_press_nxt  = 1'b0;
      case (r_state)
         DB_STABLE: begin
            if (w_sync != r_stable) begin
               w_state_nxt = DB_PENDING;
               w_cnt_nxt   = CW'(1);
            end else begin
               w_cnt_nxt   = '0;
            end
         end
         DB_PENDING: begin
            if (w_sync == r_stable) begin
               w_state_nxt = DB_STABLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == TERM) begin
               w_state_nxt  = DB_STABLE;
               w_cnt_nxt    = '0;
               w_stable_nxt = w_sync;
               w_press_nxt  = w_sync;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nxt = DB_STABLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign o_stable = r_stable;
   assign o_press  = r_press;
endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-bit debounced pushbutton nibble for the CPU; BTN_STICKY_EN latches presses until ack
module button_conditioner
   import nibbler_io_pkg::*;
#(
   parameter int WIDTH           = NIB_W,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input logic                 clk,
   input logic                 reset,
   button_conditioner_if.slave bus
);
   logic [WIDTH-1:0] w_stable;
   logic [WIDTH-1:0] w_press;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
         .clk      (clk),
         .reset    (reset),
         .i_raw    (bus.btn_raw[g]),
         .o_stable (w_stable[g]),
         .o_press  (w_press[g])
      );
   end

`ifdef BTN_STICKY_EN
   logic [WIDTH-1:0] r_sticky;

   // A press arriving in the same cycle as ack must survive, so set dominates clear.
   always_ff @(posedge clk) begin
      if (reset) r_sticky <= '0;
      else       r_sticky <= w_press | (r_sticky & ~{WIDTH{bus.ack}});
   end

   assign bus.buttons = r_sticky;
`else
   logic w_unused_ack;
   assign w_unused_ack = bus.ack;
   assign bus.buttons  = w_stable;
`endif

   assign bus.press_pulse = w_press;
endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed and random checks of button_conditioner against a sliding-window model
module tb_button_conditioner;
   import nibbler_io_pkg::*;

   localparam int W = NIB_W;
   localparam int S = 2;
   localparam int D = 4;
`ifdef BTN_STICKY_EN
   localparam int LAT = S + D + 1;
`else
   localparam int LAT = S + D;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   button_conditioner_if #(.WIDTH(W)) bus ();

   button_conditioner #(
      .WIDTH           (W),
      .SYNC_STAGES     (S),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int               n_checks = 0;
   int               n_errors = 0;
   int               pcnt [W];
   int               hold [W];
   int               lat;
   logic [W-1:0]     cur_raw;
   logic [W-1:0]     raw_q [$];
   logic [W-1:0]     obs_q [$];
   logic [W-1:0]     m_stable = '0;
   logic [W-1:0]     m_press  = '0;
   logic [W-1:0]     m_sticky = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // A level is accepted once the last D synchronised samples all differ from the held level.
   task automatic model_edge(input logic [W-1:0] raw, input logic ack_v, input logic rst_v);
      logic [W-1:0] obs;
      logic [W-1:0] nstable;
      logic [W-1:0] npress;
      bit           all_diff;
      if (rst_v) begin
         raw_q.delete();
         obs_q.delete();
         m_stable = '0;
         m_press  = '0;
         m_sticky = '0;
         return;
      end
      obs = (raw_q.size() >= S) ? raw_q[raw_q.size() - S] : '0;
      raw_q.push_back(raw);
      if (raw_q.size() > S) void'(raw_q.pop_front());
      obs_q.push_back(obs);
      if (obs_q.size() > D) void'(obs_q.pop_front());
      for (int i = 0; i < W; i++) begin
         all_diff = (obs_q.size() == D);
         foreach (obs_q[j]) if (obs_q[j][i] == m_stable[i]) all_diff = 1'b0;
         nstable[i] = all_diff ? ~m_stable[i] : m_stable[i];
         npress[i]  = all_diff & ~m_stable[i];
      end
      m_sticky = m_press | (m_sticky & ~{W{ack_v}});
      m_press  = npress;
      m_stable = nstable;
   endtask

   task automatic step(input logic [W-1:0] raw, input logic ack_v, input logic rst_v);
      logic [W-1:0] exp_buttons;
      bus.btn_raw = raw;
      bus.ack     = ack_v;
      reset       = rst_v;
      @(posedge clk);
      model_edge(raw, ack_v, rst_v);
      #1;
`ifdef BTN_STICKY_EN
      exp_buttons = m_sticky;
`else
      exp_buttons = m_stable;
`endif
      check("buttons", bus.buttons, exp_buttons);
      check("press_pulse", bus.press_pulse, m_press);
      for (int i = 0; i < W; i++) pcnt[i] += int'(bus.press_pulse[i]);
   endtask

   task automatic hold_until(input int b, input logic v, output int n);
      n = 0;
      do begin
         step(cur_raw, 1'b0, 1'b0);
         n++;
      end while (bus.buttons[b] !== v && n < 20);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      foreach (pcnt[i]) pcnt[i] = 0;
      foreach (hold[i]) hold[i] = 0;
      bus.ack = 1'b0;
      cur_raw = '1;
      repeat (3) begin
         step(cur_raw, 1'b0, 1'b1);
         check("rst_buttons", bus.buttons, 0);
         check("rst_pulse", bus.press_pulse, 0);
      end
      cur_raw = '0;
      repeat (8) step(cur_raw, 1'b0, 1'b0);

      foreach (pcnt[i]) pcnt[i] = 0;
      cur_raw = 4'b0001;
      hold_until(0, 1'b1, lat);
      check("press_lat", lat, LAT);
      repeat (4) step(cur_raw, 1'b0, 1'b0);
      check("press_cnt", pcnt[0], 1);

      cur_raw = 4'b0011;
      repeat (3) step(cur_raw, 1'b0, 1'b0);
      cur_raw = 4'b0001;
      repeat (10) step(cur_raw, 1'b0, 1'b0);
      check("glitch_cnt", pcnt[1], 0);
      check("glitch_btn", bus.buttons[1], 0);

      step(4'b0101, 1'b0, 1'b0);
      step(4'b0001, 1'b0, 1'b0);
      step(4'b0101, 1'b0, 1'b0);
      step(4'b0001, 1'b0, 1'b0);
      cur_raw = 4'b0101;
      hold_until(2, 1'b1, lat);
      check("bounce_lat", lat, LAT);
      repeat (4) step(cur_raw, 1'b0, 1'b0);
      check("bounce_cnt", pcnt[2], 1);

      cur_raw = '0;
`ifndef BTN_STICKY_EN
      hold_until(0, 1'b0, lat);
      check("release_lat", lat, LAT);
      repeat (4) step(cur_raw, 1'b0, 1'b0);
      check("release_cnt", pcnt[0], 1);
`else
      repeat (10) step(cur_raw, 1'b0, 1'b0);
      check("sticky_hold", bus.buttons, 4'b0101);
      step(cur_raw, 1'b1, 1'b0);
      check("sticky_ack", bus.buttons, 0);
`endif

      cur_raw = 4'b0010;
      repeat (4) step(cur_raw, 1'b0, 1'b0);
      step(cur_raw, 1'b0, 1'b1);
      check("midrst_btn", bus.buttons, 0);
      hold_until(1, 1'b1, lat);
      check("midrst_lat", lat, LAT);

`ifdef BTN_STICKY_EN
      cur_raw = 4'b1000;
      repeat (10) step(cur_raw, 1'b0, 1'b0);
      cur_raw = '0;
      repeat (10) step(cur_raw, 1'b0, 1'b0);
      check("sticky3_hold", bus.buttons[3], 1);
      step(cur_raw, 1'b1, 1'b0);
      check("sticky3_clr", bus.buttons[3], 0);
`endif

      repeat (3000) begin
         for (int i = 0; i < W; i++) begin
            if (hold[i] == 0) begin
               cur_raw[i] = 1'($urandom_range(0, 1));
               hold[i]    = int'($urandom_range(1, 2 * D + 2));
            end
            hold[i]--;
         end
         step(cur_raw, $urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
